// File: rtl/axi4_mem_tester.sv
// rtl/axi4_mem_tester.sv - self-checking AXI4 INCR-burst write/read-back memory tester
//
// Writes an address-derived pattern over NUM_BURSTS bursts of BURST_LEN beats
// starting at BASE_ADDR, reads the region back and compares every beat.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   start, invert         run request (sampled in IDLE) and pattern inversion for that run
//   busy, done, pass      run status; done is a one-cycle pulse, pass holds until next start
//   err_cnt               saturating mismatch count
//   first_err_addr        word address of the first failing beat
//   aw*/w*/b*             AXI write address, data and response channels (master side)
//   ar*/r*                AXI read address and data channels (master side)
module axi4_mem_tester #(
   parameter int                 A_WIDTH    = 25,
   parameter int                 D_WIDTH    = 16,
   parameter int                 BURST_LEN  = 64,
   parameter int                 NUM_BURSTS = 16,
   parameter logic [A_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [31:0]        PAT_XOR    = 32'h0000A5C3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               invert,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [15:0]        err_cnt,
   output logic [A_WIDTH-1:0] first_err_addr,
   output logic               awvalid,
   input  logic               awready,
   output logic [A_WIDTH-1:0] awaddr,
   output logic [7:0]         awlen,
   output logic               wvalid,
   input  logic               wready,
   output logic               wlast,
   output logic [D_WIDTH-1:0] wdata,
   input  logic               bvalid,
   output logic               bready,
   output logic               arvalid,
   input  logic               arready,
   output logic [A_WIDTH-1:0] araddr,
   output logic [7:0]         arlen,
   input  logic               rvalid,
   output logic               rready,
   input  logic               rlast,
   input  logic [D_WIDTH-1:0] rdata
);

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

   localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);
   localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);

   state_t               state_q, state_d;
   logic [15:0]          k_q, k_d;
   logic [7:0]           j_q, j_d;
   // Word address of the current beat; it runs continuously across bursts,
   // so the next burst's start address is simply its value after the last beat.
   logic [A_WIDTH-1:0]   addr_q, addr_d;
   logic                 inv_q, inv_d;
   logic                 awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
   logic                 bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
   logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [A_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [A_WIDTH-1:0]   fea_q, fea_d;
   logic [D_WIDTH-1:0]   wdata_q, wdata_d;
   logic [15:0]          err_cnt_q, err_cnt_d;
   logic                 beat_err;

   function automatic logic [D_WIDTH-1:0] pat(input logic [A_WIDTH-1:0] a, input logic inv);
      pat = a[D_WIDTH-1:0] ^ PAT_XOR[D_WIDTH-1:0] ^ {D_WIDTH{inv}};
   endfunction

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      j_d       = j_q;
      addr_d    = addr_q;
      inv_d     = inv_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      wlast_d   = wlast_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      pass_d    = pass_q;
      awaddr_d  = awaddr_q;
      araddr_d  = araddr_q;
      fea_d     = fea_q;
      wdata_d   = wdata_q;
      err_cnt_d = err_cnt_q;
      beat_err  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               inv_d     = invert;
               k_d       = '0;
               j_d       = '0;
               addr_d    = BASE_ADDR;
               awaddr_d  = BASE_ADDR;
               awvalid_d = 1'b1;
               err_cnt_d = '0;
               fea_d     = '0;
               pass_d    = 1'b0;
               busy_d    = 1'b1;
               state_d   = S_AW;
            end
         end
         S_AW: begin
            if (awready) begin
               awvalid_d = 1'b0;
               wvalid_d  = 1'b1;
               wdata_d   = pat(addr_q, inv_q);
               wlast_d   = (j_q == LAST_BEAT);
               state_d   = S_W;
            end
         end
         S_W: begin
            if (wready) begin
               addr_d = addr_q + 1'b1;
               if (j_q == LAST_BEAT) begin
                  wvalid_d = 1'b0;
                  wlast_d  = 1'b0;
                  j_d      = '0;
                  bready_d = 1'b1;
                  state_d  = S_B;
               end else begin
                  j_d     = j_q + 8'd1;
                  wdata_d = pat(addr_q + 1'b1, inv_q);
                  wlast_d = ((j_q + 8'd1) == LAST_BEAT);
               end
            end
         end
         S_B: begin
            if (bvalid) begin
               bready_d = 1'b0;
               if (k_q == LAST_BURST) begin
                  k_d       = '0;
                  addr_d    = BASE_ADDR;
                  araddr_d  = BASE_ADDR;
                  arvalid_d = 1'b1;
                  state_d   = S_AR;
               end else begin
                  k_d       = k_q + 16'd1;
                  awaddr_d  = addr_q;
                  awvalid_d = 1'b1;
                  state_d   = S_AW;
               end
            end
         end
         S_AR: begin
            if (arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_R;
            end
         end
         S_R: begin
            if (rvalid) begin
               // Data and rlast errors on the same beat count as one error.
               beat_err = (rdata != pat(addr_q, inv_q)) || (rlast != (j_q == LAST_BEAT));
               if (beat_err) begin
                  // err_cnt never wraps, so zero means no failure seen yet this run.
                  if (err_cnt_q == 16'd0) fea_d = addr_q;
                  if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
               end
               addr_d = addr_q + 1'b1;
               if (j_q == LAST_BEAT) begin
                  j_d      = '0;
                  rready_d = 1'b0;
                  if (k_q == LAST_BURST) begin
                     k_d     = '0;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     pass_d  = (err_cnt_d == 16'd0);
                     state_d = S_DONE;
                  end else begin
                     k_d       = k_q + 16'd1;
                     araddr_d  = addr_q + 1'b1;
                     arvalid_d = 1'b1;
                     state_d   = S_AR;
                  end
               end else begin
                  j_d = j_q + 8'd1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         j_q       <= '0;
         addr_q    <= '0;
         inv_q     <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         wlast_q   <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         fea_q     <= '0;
         wdata_q   <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         j_q       <= j_d;
         addr_q    <= addr_d;
         inv_q     <= inv_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         wlast_q   <= wlast_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         awaddr_q  <= awaddr_d;
         araddr_q  <= araddr_d;
         fea_q     <= fea_d;
         wdata_q   <= wdata_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_cnt        = err_cnt_q;
   assign first_err_addr = fea_q;
   assign awvalid        = awvalid_q;
   assign awaddr         = awaddr_q;
   assign awlen          = LAST_BEAT;
   assign wvalid         = wvalid_q;
   assign wlast          = wlast_q;
   assign wdata          = wdata_q;
   assign bready         = bready_q;
   assign arvalid        = arvalid_q;
   assign araddr         = araddr_q;
   assign arlen          = LAST_BEAT;
   assign rready         = rready_q;

endmodule

// File: tb/tb_axi4_mem_tester.sv
// tb/tb_axi4_mem_tester.sv - directed bench for axi4_mem_tester with a shared AXI slave model
module tb_axi4_mem_tester;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, invert, sel;
   int   errors = 0;
   int   checks = 0;

   logic        awready, wready, bvalid, arready, rvalid, rlast;
   logic [15:0] rdata;

   // x0: BASE_ADDR=0, two bursts; x1: BASE_ADDR near the top, one burst (wrap case)
   logic        x0_busy, x0_done, x0_pass, x0_awvalid, x0_wvalid, x0_wlast, x0_bready, x0_arvalid, x0_rready;
   logic [15:0] x0_err, x0_wdata;
   logic [24:0] x0_fea, x0_awaddr, x0_araddr;
   logic [7:0]  x0_awlen, x0_arlen;
   logic        x1_busy, x1_done, x1_pass, x1_awvalid, x1_wvalid, x1_wlast, x1_bready, x1_arvalid, x1_rready;
   logic [15:0] x1_err, x1_wdata;
   logic [24:0] x1_fea, x1_awaddr, x1_araddr;
   logic [7:0]  x1_awlen, x1_arlen;

   logic        s_busy, s_done, s_pass, s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready;
   logic [15:0] s_err, s_wdata;
   logic [24:0] s_fea, s_awaddr, s_araddr;
   logic [7:0]  s_awlen, s_arlen;

   assign s_busy    = sel ? x1_busy    : x0_busy;
   assign s_done    = sel ? x1_done    : x0_done;
   assign s_pass    = sel ? x1_pass    : x0_pass;
   assign s_awvalid = sel ? x1_awvalid : x0_awvalid;
   assign s_wvalid  = sel ? x1_wvalid  : x0_wvalid;
   assign s_wlast   = sel ? x1_wlast   : x0_wlast;
   assign s_bready  = sel ? x1_bready  : x0_bready;
   assign s_arvalid = sel ? x1_arvalid : x0_arvalid;
   assign s_rready  = sel ? x1_rready  : x0_rready;
   assign s_err     = sel ? x1_err     : x0_err;
   assign s_wdata   = sel ? x1_wdata   : x0_wdata;
   assign s_fea     = sel ? x1_fea     : x0_fea;
   assign s_awaddr  = sel ? x1_awaddr  : x0_awaddr;
   assign s_araddr  = sel ? x1_araddr  : x0_araddr;
   assign s_awlen   = sel ? x1_awlen   : x0_awlen;
   assign s_arlen   = sel ? x1_arlen   : x0_arlen;

   axi4_mem_tester #(.A_WIDTH(25), .D_WIDTH(16), .BURST_LEN(4), .NUM_BURSTS(2),
                     .BASE_ADDR(25'h0000000), .PAT_XOR(32'h0000A5C3)) dut (
      .clk(clk), .rst(rst), .start(start & ~sel), .invert(invert),
      .busy(x0_busy), .done(x0_done), .pass(x0_pass), .err_cnt(x0_err), .first_err_addr(x0_fea),
      .awvalid(x0_awvalid), .awready(awready), .awaddr(x0_awaddr), .awlen(x0_awlen),
      .wvalid(x0_wvalid), .wready(wready), .wlast(x0_wlast), .wdata(x0_wdata),
      .bvalid(bvalid), .bready(x0_bready),
      .arvalid(x0_arvalid), .arready(arready), .araddr(x0_araddr), .arlen(x0_arlen),
      .rvalid(rvalid), .rready(x0_rready), .rlast(rlast), .rdata(rdata));

   axi4_mem_tester #(.A_WIDTH(25), .D_WIDTH(16), .BURST_LEN(4), .NUM_BURSTS(1),
                     .BASE_ADDR(25'h1FFFFFE), .PAT_XOR(32'h0000A5C3)) dut_wrap (
      .clk(clk), .rst(rst), .start(start & sel), .invert(invert),
      .busy(x1_busy), .done(x1_done), .pass(x1_pass), .err_cnt(x1_err), .first_err_addr(x1_fea),
      .awvalid(x1_awvalid), .awready(awready), .awaddr(x1_awaddr), .awlen(x1_awlen),
      .wvalid(x1_wvalid), .wready(wready), .wlast(x1_wlast), .wdata(x1_wdata),
      .bvalid(bvalid), .bready(x1_bready),
      .arvalid(x1_arvalid), .arready(arready), .araddr(x1_araddr), .arlen(x1_arlen),
      .rvalid(rvalid), .rready(x1_rready), .rlast(rlast), .rdata(rdata));

   // ---------------- slave model (acts on the negedge) ----------------
   logic [15:0] mem [256];
   bit          bad_data [256];
   bit          bad_last [256];
   bit          stall;
   logic [24:0] wptr, rptr;
   int          rcnt, bpend, wbeat, aw_wait;
   logic [24:0] aw_log[$], ar_log[$], wa_log[$];
   logic [15:0] wd_log[$];
   int          done_cnt = 0, wlast_errs = 0, stall_viol = 0, aw_stall_cyc = 0, len_errs = 0;
   logic        p_aw, p_w, p_b, p_ar, p_r, p_wlast, p_awstall, p_wstall, p_arstall;
   logic [24:0] p_awaddr, p_araddr;
   logic [15:0] p_wdata;

   always @(negedge clk) begin
      if (rst) begin
         rcnt = 0; bpend = 0; wbeat = 0; aw_wait = 0; wptr = '0; rptr = '0;
         awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
         rvalid = 1'b0; rlast = 1'b0; rdata = '0;
         p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0; p_wlast = 0;
         p_awstall = 0; p_wstall = 0; p_arstall = 0;
         p_awaddr = '0; p_araddr = '0; p_wdata = '0;
      end else begin
         if (s_done) done_cnt++;
         if (p_awstall && (!s_awvalid || s_awaddr !== p_awaddr)) stall_viol++;
         if (p_wstall && (!s_wvalid || s_wdata !== p_wdata || s_wlast !== p_wlast)) stall_viol++;
         if (p_arstall && (!s_arvalid || s_araddr !== p_araddr)) stall_viol++;
         if (s_awvalid && s_awlen !== 8'd3) len_errs++;
         if (s_arvalid && s_arlen !== 8'd3) len_errs++;
         // handshakes that completed at the posedge just passed
         if (p_aw) begin aw_log.push_back(p_awaddr); wptr = p_awaddr; aw_wait = 0; end
         if (p_w) begin
            mem[wptr[7:0]] = p_wdata;
            wa_log.push_back(wptr);
            wd_log.push_back(p_wdata);
            if (p_wlast !== (wbeat == 3)) wlast_errs++;
            if (wbeat == 3) bpend++;
            wbeat = (wbeat == 3) ? 0 : wbeat + 1;
            wptr  = wptr + 25'd1;
         end
         if (p_b) bpend--;
         if (p_ar) begin ar_log.push_back(p_araddr); rptr = p_araddr; rcnt = 4; end
         if (p_r) begin rptr = rptr + 25'd1; rcnt--; end
         // drive the next cycle
         if (s_awvalid) aw_wait++;
         awready = !stall || (aw_wait > 3);
         if (s_awvalid && !awready) aw_stall_cyc++;
         wready  = !stall || ($urandom_range(0, 1) == 1);
         arready = !stall || ($urandom_range(0, 1) == 1);
         bvalid  = (bpend > 0) && (!stall || ($urandom_range(0, 1) == 1));
         rvalid  = (rcnt > 0) && (!stall || ($urandom_range(0, 1) == 1));
         rdata   = mem[rptr[7:0]] ^ {15'd0, bad_data[rptr[7:0]]};
         rlast   = (rcnt == 1) ^ bad_last[rptr[7:0]];
         p_aw = s_awvalid && awready;  p_awstall = s_awvalid && !awready; p_awaddr = s_awaddr;
         p_w  = s_wvalid && wready;    p_wstall  = s_wvalid && !wready;   p_wdata = s_wdata;
         p_wlast = s_wlast;
         p_b  = bvalid && s_bready;
         p_ar = s_arvalid && arready;  p_arstall = s_arvalid && !arready; p_araddr = s_araddr;
         p_r  = rvalid && s_rready;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic run(input bit inv, input bit use_wrap, input int poke);
      int d0;
      d0 = done_cnt;
      @(posedge clk); #2 sel = use_wrap; invert = inv; start = 1'b1;
      @(posedge clk); #2 start = 1'b0; invert = 1'b0;
      for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
         @(negedge clk); #1;
         start = (i == poke);
      end
      start = 1'b0;
      checks++;
      if (done_cnt == d0) begin
         errors++; $display("FAIL run_timeout: done_cnt=%0d required>%0d", done_cnt, d0);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk); #1;
      checks++;
      if ({s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready, s_busy, s_done, s_pass} !== 9'd0) begin
         errors++; $display("FAIL reset_ctrl: got %b required 000000000",
            {s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready, s_busy, s_done, s_pass});
      end
      checks++;
      if ({s_err, s_fea, s_awaddr, s_araddr, s_wdata} !== 107'd0) begin
         errors++; $display("FAIL reset_regs: err=%h fea=%h awaddr=%h araddr=%h wdata=%h required all 0",
            s_err, s_fea, s_awaddr, s_araddr, s_wdata);
      end
      checks++;
      if (s_awlen !== 8'd3 || s_arlen !== 8'd3) begin
         errors++; $display("FAIL reset_len: awlen=%0d arlen=%0d required 3", s_awlen, s_arlen);
      end
   endtask

   task automatic test_basic();
      int a0, r0, w0, d0;
      logic [15:0] exp_wd;
      a0 = aw_log.size(); r0 = ar_log.size(); w0 = wd_log.size(); d0 = done_cnt;
      run(1'b0, 1'b0, -1);
      checks++;
      if (s_pass !== 1'b1 || s_err !== 16'd0 || s_busy !== 1'b0) begin
         errors++; $display("FAIL basic_result: pass=%b err=%0d busy=%b required 1 0 0", s_pass, s_err, s_busy);
      end
      checks++;
      if (aw_log.size() - a0 != 2 || ar_log.size() - r0 != 2 || wd_log.size() - w0 != 8) begin
         errors++; $display("FAIL basic_counts: aw=%0d ar=%0d w=%0d required 2 2 8",
            aw_log.size() - a0, ar_log.size() - r0, wd_log.size() - w0);
      end else begin
         checks++;
         if (aw_log[a0] !== 25'd0 || aw_log[a0+1] !== 25'd4 || ar_log[r0] !== 25'd0 || ar_log[r0+1] !== 25'd4) begin
            errors++; $display("FAIL basic_addrs: aw=%h,%h ar=%h,%h required 0,4 0,4",
               aw_log[a0], aw_log[a0+1], ar_log[r0], ar_log[r0+1]);
         end
         // A5C3, A5C2, A5C1, A5C0, A5C7, A5C6, A5C5, A5C4
         for (int i = 0; i < 8; i++) begin
            exp_wd = 16'hA5C3 ^ 16'(i);
            checks++;
            if (wd_log[w0+i] !== exp_wd) begin
               errors++; $display("FAIL basic_wdata[%0d]: got %h required %h", i, wd_log[w0+i], exp_wd);
            end
         end
      end
      checks++;
      if (wlast_errs != 0 || len_errs != 0) begin
         errors++; $display("FAIL basic_wlast_len: wlast_errs=%0d len_errs=%0d required 0 0", wlast_errs, len_errs);
      end
      // still in the DONE cycle: a start here must be ignored
      start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (s_busy !== 1'b0 || aw_log.size() - a0 != 2 || done_cnt - d0 != 1) begin
         errors++; $display("FAIL start_in_done: busy=%b aw=%0d dones=%0d required 0 2 1",
            s_busy, aw_log.size() - a0, done_cnt - d0);
      end
      checks++;
      if (s_pass !== 1'b1 || s_err !== 16'd0) begin
         errors++; $display("FAIL result_hold: pass=%b err=%0d required 1 0", s_pass, s_err);
      end
   endtask

   task automatic test_invert();
      int w0;
      w0 = wd_log.size();
      run(1'b1, 1'b0, -1);
      checks++;
      if (wd_log.size() - w0 != 8) begin
         errors++; $display("FAIL invert_count: got %0d required 8", wd_log.size() - w0);
      end else begin
         checks++;
         if (wd_log[w0] !== 16'h5A3C || wd_log[w0+7] !== 16'h5A3B) begin
            errors++; $display("FAIL invert_wdata: got %h,%h required 5a3c,5a3b", wd_log[w0], wd_log[w0+7]);
         end
      end
      checks++;
      if (s_pass !== 1'b1 || s_err !== 16'd0) begin
         errors++; $display("FAIL invert_result: pass=%b err=%0d required 1 0", s_pass, s_err);
      end
   endtask

   task automatic test_corrupt_data();
      bad_data[5] = 1'b1;
      run(1'b0, 1'b0, -1);
      bad_data[5] = 1'b0;
      checks++;
      if (s_err !== 16'd1 || s_fea !== 25'd5 || s_pass !== 1'b0) begin
         errors++; $display("FAIL corrupt_data: err=%0d fea=%h pass=%b required 1 5 0", s_err, s_fea, s_pass);
      end
   endtask

   task automatic test_rlast();
      // beat 2: rlast early; beat 6: data and rlast both wrong -> one error
      bad_last[2] = 1'b1; bad_last[6] = 1'b1; bad_data[6] = 1'b1;
      run(1'b0, 1'b0, -1);
      bad_last[2] = 1'b0; bad_last[6] = 1'b0; bad_data[6] = 1'b0;
      checks++;
      if (s_err !== 16'd2 || s_fea !== 25'd2 || s_pass !== 1'b0) begin
         errors++; $display("FAIL rlast_err: err=%0d fea=%h pass=%b required 2 2 0", s_err, s_fea, s_pass);
      end
   endtask

   task automatic test_stall();
      int a0, w0, d0, v0, s0;
      logic [15:0] exp_wd;
      a0 = aw_log.size(); w0 = wd_log.size(); d0 = done_cnt; v0 = stall_viol; s0 = aw_stall_cyc;
      stall = 1'b1;
      run(1'b0, 1'b0, 10);   // start poked mid-run must be ignored
      stall = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (stall_viol != v0 || aw_stall_cyc - s0 != 6) begin
         errors++; $display("FAIL stall_stable: violations=%0d aw_stall=%0d required 0 6",
            stall_viol - v0, aw_stall_cyc - s0);
      end
      checks++;
      if (aw_log.size() - a0 != 2 || wd_log.size() - w0 != 8 || done_cnt - d0 != 1) begin
         errors++; $display("FAIL stall_counts: aw=%0d w=%0d dones=%0d required 2 8 1",
            aw_log.size() - a0, wd_log.size() - w0, done_cnt - d0);
      end else begin
         for (int i = 0; i < 8; i++) begin
            exp_wd = 16'hA5C3 ^ 16'(i);
            checks++;
            if (wd_log[w0+i] !== exp_wd) begin
               errors++; $display("FAIL stall_wdata[%0d]: got %h required %h", i, wd_log[w0+i], exp_wd);
            end
         end
      end
      checks++;
      if (s_pass !== 1'b1 || s_err !== 16'd0) begin
         errors++; $display("FAIL stall_result: pass=%b err=%0d required 1 0", s_pass, s_err);
      end
   endtask

   task automatic test_wrap();
      int a0, w0;
      logic [24:0] exp_a [4];
      logic [15:0] exp_d [4];
      exp_a = '{25'h1FFFFFE, 25'h1FFFFFF, 25'h0000000, 25'h0000001};
      exp_d = '{16'h5A3D, 16'h5A3C, 16'hA5C3, 16'hA5C2};
      a0 = aw_log.size(); w0 = wd_log.size();
      run(1'b0, 1'b1, -1);
      checks++;
      if (aw_log.size() - a0 != 1 || wd_log.size() - w0 != 4) begin
         errors++; $display("FAIL wrap_counts: aw=%0d w=%0d required 1 4", aw_log.size() - a0, wd_log.size() - w0);
      end else begin
         checks++;
         if (aw_log[a0] !== 25'h1FFFFFE) begin
            errors++; $display("FAIL wrap_awaddr: got %h required 1fffffe", aw_log[a0]);
         end
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa_log[w0+i] !== exp_a[i] || wd_log[w0+i] !== exp_d[i]) begin
               errors++; $display("FAIL wrap_beat[%0d]: addr=%h data=%h required %h %h",
                  i, wa_log[w0+i], wd_log[w0+i], exp_a[i], exp_d[i]);
            end
         end
      end
      checks++;
      if (s_pass !== 1'b1 || s_err !== 16'd0) begin
         errors++; $display("FAIL wrap_result: pass=%b err=%0d required 1 0", s_pass, s_err);
      end
      @(posedge clk); #2 sel = 1'b0;
   endtask

   task automatic test_reset_mid();
      int a0;
      bit found;
      found = 1'b0;
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge clk); #1;
         found = s_wvalid && (s_awaddr == 25'd4);
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL midreset_reach_w: wvalid=%b awaddr=%h required 1 4", s_wvalid, s_awaddr);
      end
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready, s_busy} !== 7'd0) begin
         errors++; $display("FAIL midreset_ctrl: got %b required 0000000",
            {s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready, s_busy});
      end
      checks++;
      if (s_err !== 16'd0 || s_awaddr !== 25'd0) begin
         errors++; $display("FAIL midreset_regs: err=%0d awaddr=%h required 0 0", s_err, s_awaddr);
      end
      a0 = aw_log.size();
      run(1'b0, 1'b0, -1);
      checks++;
      if (s_pass !== 1'b1 || s_err !== 16'd0 || aw_log.size() - a0 != 2) begin
         errors++; $display("FAIL midreset_rerun: pass=%b err=%0d aw=%0d required 1 0 2",
            s_pass, s_err, aw_log.size() - a0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; invert = 1'b0; sel = 1'b0; stall = 1'b0;
      for (int i = 0; i < 256; i++) begin
         bad_data[i] = 1'b0; bad_last[i] = 1'b0; mem[i] = 16'hDEAD;
      end
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      test_reset();
      test_basic();
      test_invert();
      test_corrupt_data();
      test_rlast();
      test_stall();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi4_mem_tester.md
Name: axi4_mem_tester

Overview:
- Self-checking AXI4 burst master that sits directly upstream of ddr_sdram_ctrl, in place of or beside the UART bridge.
- On `start` it writes a deterministic address-derived pattern over a region using INCR bursts. It then reads the region back, compares every beat and reports the error count, the first failing address and pass/fail.
- Used for board bring-up and soak testing of the DDR path without a host.

Parameters:
- A_WIDTH, 25, AXI address width. Addresses are in D_WIDTH-word units, matching the controller.
- D_WIDTH, 16, AXI data width.
- BURST_LEN, 64, beats per burst (1..256); awlen/arlen = BURST_LEN-1.
- NUM_BURSTS, 16, bursts per pass (1..65535).
- BASE_ADDR, 0, first word address of the test region.
- PAT_XOR, 16'hA5C3, XOR key applied to the expected data (lower D_WIDTH bits used).

Ports:
- clk  in  1  single clock; same clock as the controller's AXI side.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- invert  in  1  sampled with start; when 1, the pattern is bitwise inverted for this run.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  valid from the done pulse until the next accepted start; 1 iff err_cnt==0.
- err_cnt  out  16  mismatch count, saturating.
- first_err_addr  out  A_WIDTH  word address of the first mismatch.
- awvalid  out  1, awready  in  1, awaddr  out  A_WIDTH, awlen  out  8.
- wvalid  out  1, wready  in  1, wlast  out  1, wdata  out  D_WIDTH.
- bvalid  in  1, bready  out  1.
- arvalid  out  1, arready  in  1, araddr  out  A_WIDTH, arlen  out  8.
- rvalid  in  1, rready  out  1, rlast  in  1, rdata  in  D_WIDTH.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE.
  - Outputs cleared: awvalid, wvalid, wlast, bready, arvalid, rready, busy, done and pass all 0.
  - Counters and addresses cleared: err_cnt=0, first_err_addr=0, awaddr=araddr=0, wdata=0.
  - awlen=arlen=BURST_LEN-1 at all times.
- Reset mid-run aborts immediately with no AXI cleanup. The integrator resets the controller together with this block.
- Pattern: expected data for word address a is P(a) = (a[D_WIDTH-1:0] ^ PAT_XOR), inverted when invert was latched as 1.
- Beat address: burst k, beat j → a = BASE_ADDR + k*BURST_LEN + j, modulo 2^A_WIDTH (wraps silently).
- FSM states: IDLE → AW → W → B → (next burst: AW | all written: AR) → R → (next burst: AR | all read: DONE) → IDLE.
- IDLE:
  - On start=1, latch invert and set burst counter k=0, beat counter j=0.
  - Clear err_cnt, first_err_addr and pass; set busy=1; go to AW.
- AW: awvalid=1 with awaddr stable until the awready handshake cycle. Next cycle awvalid=0, go to W.
- W:
  - wvalid=1 continuously; wdata=P(a) for the current beat; wlast=1 iff j==BURST_LEN-1.
  - Advance j only on wvalid&wready.
  - On the last handshake: wvalid=0, j=0, go to B.
  - W data is never issued before the AW handshake completes.
- B: bready=1. On bvalid, increment k; if k reaches NUM_BURSTS, reset k=0 and go to AR, else go to AW. Write response content is not checked.
- AR: same handshake rule as AW, using araddr. Then go to R.
- R:
  - rready=1.
  - On each rvalid beat, compare rdata with P(a). On mismatch, err_cnt += 1, saturating at 16'hFFFF. If this is the first mismatch of the run, capture first_err_addr=a.
  - A beat whose rlast ≠ (j==BURST_LEN-1) also counts as one error. It counts once per beat even if the data also mismatches.
  - Leave R after the beat where j==BURST_LEN-1, regardless of rlast.
- DONE:
  - One cycle: done=1, busy=0, pass=(err_cnt==0) using the final count, including the last beat.
  - Then return to IDLE. Results hold until the next accepted start.
- start while busy is ignored. start in the DONE cycle is also ignored.
- Latency: no combinational path from any AXI input to any AXI output; all outputs are registered.

Test Plan:
- Ideal slave model (ready always 1, zero-latency memory), BURST_LEN=4, NUM_BURSTS=2, BASE_ADDR=0, PAT_XOR=16'hA5C3, start → 2 AW (addr 0, 4; awlen=3) then 2 AR; wdata 0xA5C3, 0xA5C2, 0xA5C1, 0xA5C0…; done pulses once; pass=1; err_cnt=0.
- Same run with invert=1 → wdata[0]=0x5A3C; pass=1.
- Slave corrupts the read beat at address 5 (bit 0 flipped) → err_cnt=1, first_err_addr=5, pass=0.
- Slave with random ready/valid stalls (awready delayed 3 cycles, wready 50% duty) → awaddr/awvalid/wdata stable while stalled; beat count exact; pass=1.
- BASE_ADDR=2^25-2, BURST_LEN=4, NUM_BURSTS=1 → addresses 0x1FFFFFE, 0x1FFFFFF, 0x0, 0x1 written; pass=1.
- rst=1 asserted mid-W for one cycle → next cycle all valids 0, busy=0, err_cnt=0. A new start then runs to pass=1 against a freshly reset slave.
